// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - opcode, state, instruction-class and strobe-index definitions for control_sequencer
package cu_pkg;

    localparam int OPC_W = 5;
    localparam int CNT_W = 8;

    typedef enum logic [OPC_W-1:0] {
        OP_LD   = 5'd0,
        OP_LDI  = 5'd1,
        OP_ST   = 5'd2,
        OP_ADD  = 5'd3,
        OP_SUB  = 5'd4,
        OP_AND  = 5'd5,
        OP_OR   = 5'd6,
        OP_SHR  = 5'd7,
        OP_SHL  = 5'd8,
        OP_ROR  = 5'd9,
        OP_ROL  = 5'd10,
        OP_ADDI = 5'd11,
        OP_ANDI = 5'd12,
        OP_ORI  = 5'd13,
        OP_MUL  = 5'd14,
        OP_DIV  = 5'd15,
        OP_NEG  = 5'd16,
        OP_NOT  = 5'd17,
        OP_BR   = 5'd18,
        OP_JR   = 5'd19,
        OP_IN   = 5'd20,
        OP_OUT  = 5'd21,
        OP_MFHI = 5'd22,
        OP_MFLO = 5'd23,
        OP_NOP  = 5'd24,
        OP_HALT = 5'd25
    } opcode_e;

    typedef enum logic [4:0] {
        S_RST  = 5'd0,
        S_F0   = 5'd1,
        S_F1   = 5'd2,
        S_F2   = 5'd3,
        S_T3   = 5'd4,
        S_T4   = 5'd5,
        S_T5   = 5'd6,
        S_T6   = 5'd7,
        S_T7   = 5'd8,
        S_HALT = 5'd9
`ifdef CU_SINGLE_STEP_EN
        , S_STEP_WAIT = 5'd10
`endif
    } state_e;

    typedef enum logic [3:0] {
        CL_NOP, CL_ALU_R, CL_ALU_I, CL_LD, CL_LDI, CL_ST, CL_MULDIV, CL_UNARY,
        CL_BR, CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_HALT
    } class_e;

    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SHR  = 4'd5;
    localparam logic [3:0] ALU_SHL  = 4'd6;
    localparam logic [3:0] ALU_ROR  = 4'd7;
    localparam logic [3:0] ALU_ROL  = 4'd8;
    localparam logic [3:0] ALU_MUL  = 4'd9;
    localparam logic [3:0] ALU_DIV  = 4'd10;
    localparam logic [3:0] ALU_NEG  = 4'd11;
    localparam logic [3:0] ALU_NOT  = 4'd12;

    localparam int SEL_GRA  = 4;
    localparam int SEL_GRB  = 3;
    localparam int SEL_GRC  = 2;
    localparam int SEL_RIN  = 1;
    localparam int SEL_ROUT = 0;

    localparam int BUS_INPORT = 8;
    localparam int BUS_BA     = 7;
    localparam int BUS_C      = 6;
    localparam int BUS_PC     = 5;
    localparam int BUS_MDR    = 4;
    localparam int BUS_ZHI    = 3;
    localparam int BUS_ZLO    = 2;
    localparam int BUS_HI     = 1;
    localparam int BUS_LO     = 0;

    localparam int LD_PC      = 9;
    localparam int LD_IR      = 8;
    localparam int LD_Y       = 7;
    localparam int LD_Z       = 6;
    localparam int LD_HI      = 5;
    localparam int LD_LO      = 4;
    localparam int LD_MAR     = 3;
    localparam int LD_MDR     = 2;
    localparam int LD_OUTPORT = 1;
    localparam int LD_CON     = 0;

    typedef struct packed {
        class_e     cls;
        logic [3:0] alu;
    } decode_t;

    // Undefined opcodes fall through to CL_NOP so they behave as a plain fetch.
    function automatic decode_t decode_op(input logic [OPC_W-1:0] opc);
        decode_t d;
        d.cls = CL_NOP;
        d.alu = ALU_NONE;
        case (opcode_e'(opc))
            OP_LD:   d.cls = CL_LD;
            OP_LDI:  d.cls = CL_LDI;
            OP_ST:   d.cls = CL_ST;
            OP_ADD:  begin d.cls = CL_ALU_R;  d.alu = ALU_ADD; end
            OP_SUB:  begin d.cls = CL_ALU_R;  d.alu = ALU_SUB; end
            OP_AND:  begin d.cls = CL_ALU_R;  d.alu = ALU_AND; end
            OP_OR:   begin d.cls = CL_ALU_R;  d.alu = ALU_OR;  end
            OP_SHR:  begin d.cls = CL_ALU_R;  d.alu = ALU_SHR; end
            OP_SHL:  begin d.cls = CL_ALU_R;  d.alu = ALU_SHL; end
            OP_ROR:  begin d.cls = CL_ALU_R;  d.alu = ALU_ROR; end
            OP_ROL:  begin d.cls = CL_ALU_R;  d.alu = ALU_ROL; end
            OP_ADDI: begin d.cls = CL_ALU_I;  d.alu = ALU_ADD; end
            OP_ANDI: begin d.cls = CL_ALU_I;  d.alu = ALU_AND; end
            OP_ORI:  begin d.cls = CL_ALU_I;  d.alu = ALU_OR;  end
            OP_MUL:  begin d.cls = CL_MULDIV; d.alu = ALU_MUL; end
            OP_DIV:  begin d.cls = CL_MULDIV; d.alu = ALU_DIV; end
            OP_NEG:  begin d.cls = CL_UNARY;  d.alu = ALU_NEG; end
            OP_NOT:  begin d.cls = CL_UNARY;  d.alu = ALU_NOT; end
            OP_BR:   d.cls = CL_BR;
            OP_JR:   d.cls = CL_JR;
            OP_IN:   d.cls = CL_IN;
            OP_OUT:  d.cls = CL_OUT;
            OP_MFHI: d.cls = CL_MFHI;
            OP_MFLO: d.cls = CL_MFLO;
            OP_HALT: d.cls = CL_HALT;
            default: d.cls = CL_NOP;
        endcase
        return d;
    endfunction

    function automatic state_e last_step_of(input class_e cls);
        state_e s;
        case (cls)
            CL_ALU_R, CL_ALU_I, CL_LDI:               s = S_T5;
            CL_LD, CL_ST:                             s = S_T7;
            CL_MULDIV, CL_BR:                         s = S_T6;
            CL_UNARY:                                 s = S_T4;
            CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO:   s = S_T3;
            default:                                  s = S_F2;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts memory wait cycles and flags a timeout when the limit is hit
module mem_wait_timer
    import cu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic clr,
    input  logic wait_en,
    input  logic ready,
    output logic timeout
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The cycle whose count would reach TIMEOUT is the last one waited.
    assign timeout = wait_en && !ready && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = '0;
        if (wait_en && !ready && !timeout) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired Moore control unit for the bus datapath; CU_SINGLE_STEP_EN adds step-gated execution
module control_sequencer
    import cu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        clr,
`ifdef CU_SINGLE_STEP_EN
    input  logic        step,
`endif
    input  logic [31:0] IR_data,
    input  logic        CON_out,
    input  logic        mem_ready,
    output logic [4:0]  sel_ctl,
    output logic [8:0]  bus_src,
    output logic [9:0]  reg_load,
    output logic        Inc_PC,
    output logic        read,
    output logic        write,
    output logic [3:0]  ALU_select,
    output logic        Run,
    output logic        mem_err,
    output logic [4:0]  state_dbg
);

`ifdef CU_SINGLE_STEP_EN
    localparam state_e FETCH_ENTRY = S_STEP_WAIT;
`else
    localparam state_e FETCH_ENTRY = S_F0;
`endif

    state_e  state_q, state_d;
    state_e  last_step, succ;
    logic    mem_err_q, mem_err_d;
    logic    mem_wait, mem_timeout;
    decode_t dec;
    logic    unused_ir_bits;

    assign dec            = decode_op(IR_data[31:32-OPC_W]);
    assign unused_ir_bits = ^IR_data[31-OPC_W:0];
    assign last_step      = last_step_of(dec.cls);
    assign mem_wait       = (state_q == S_F1)
                         || (state_q == S_T6 && dec.cls == CL_LD)
                         || (state_q == S_T7 && dec.cls == CL_ST);

    mem_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .clr     (clr),
        .wait_en (mem_wait),
        .ready   (mem_ready),
        .timeout (mem_timeout)
    );

    always_comb begin
        state_d   = state_q;
        mem_err_d = mem_err_q;
        succ      = (state_q == last_step) ? FETCH_ENTRY : state_e'(state_q + 5'd1);
        case (state_q)
            S_RST:  state_d = FETCH_ENTRY;
            S_F2: begin
                case (dec.cls)
                    CL_NOP:  state_d = FETCH_ENTRY;
                    CL_HALT: state_d = S_HALT;
                    default: state_d = S_T3;
                endcase
            end
            S_HALT: state_d = S_HALT;
`ifdef CU_SINGLE_STEP_EN
            S_STEP_WAIT: if (step) state_d = S_F0;
`endif
            S_F0, S_F1, S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (!mem_wait || mem_ready) begin
                    state_d = succ;
                end else if (mem_timeout) begin
                    state_d   = S_HALT;
                    mem_err_d = 1'b1;
                end
            end
            default: state_d = S_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= S_RST;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign state_dbg = state_q;
    assign mem_err   = mem_err_q;

    always_comb begin
        sel_ctl    = '0;
        bus_src    = '0;
        reg_load   = '0;
        Inc_PC     = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        ALU_select = ALU_NONE;
        Run        = 1'b1;
        case (state_q)
            S_F0: begin
                bus_src[BUS_PC]  = 1'b1;
                reg_load[LD_MAR] = 1'b1;
                Inc_PC           = 1'b1;
            end
            S_F1: begin
                read             = 1'b1;
                reg_load[LD_MDR] = 1'b1;
            end
            S_F2: begin
                bus_src[BUS_MDR] = 1'b1;
                reg_load[LD_IR]  = 1'b1;
            end
            S_T3: begin
                case (dec.cls)
                    CL_ALU_R, CL_ALU_I: begin
                        sel_ctl[SEL_GRB] = 1'b1; sel_ctl[SEL_ROUT] = 1'b1; reg_load[LD_Y] = 1'b1;
                    end
                    CL_LD, CL_LDI, CL_ST: begin
                        sel_ctl[SEL_GRB] = 1'b1; bus_src[BUS_BA] = 1'b1; reg_load[LD_Y] = 1'b1;
                    end
                    CL_MULDIV: begin
                        sel_ctl[SEL_GRA] = 1'b1; sel_ctl[SEL_ROUT] = 1'b1; reg_load[LD_Y] = 1'b1;
                    end
                    CL_UNARY: begin
                        sel_ctl[SEL_GRB] = 1'b1; sel_ctl[SEL_ROUT] = 1'b1;
                        ALU_select = dec.alu; reg_load[LD_Z] = 1'b1;
                    end
                    CL_BR: begin
                        sel_ctl[SEL_GRA] = 1'b1; sel_ctl[SEL_ROUT] = 1'b1; reg_load[LD_CON] = 1'b1;
                    end
                    CL_JR: begin
                        sel_ctl[SEL_GRA] = 1'b1; sel_ctl[SEL_ROUT] = 1'b1; reg_load[LD_PC] = 1'b1;
                    end
                    CL_IN: begin
                        bus_src[BUS_INPORT] = 1'b1; sel_ctl[SEL_GRA] = 1'b1; sel_ctl[SEL_RIN] = 1'b1;
                    end
                    CL_OUT: begin
                        sel_ctl[SEL_GRA] = 1'b1; sel_ctl[SEL_ROUT] = 1'b1; reg_load[LD_OUTPORT] = 1'b1;
                    end
                    CL_MFHI: begin
                        bus_src[BUS_HI] = 1'b1; sel_ctl[SEL_GRA] = 1'b1; sel_ctl[SEL_RIN] = 1'b1;
                    end
                    CL_MFLO: begin
                        bus_src[BUS_LO] = 1'b1; sel_ctl[SEL_GRA] = 1'b1; sel_ctl[SEL_RIN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (dec.cls)
                    CL_ALU_R: begin
                        sel_ctl[SEL_GRC] = 1'b1; sel_ctl[SEL_ROUT] = 1'b1;
                        ALU_select = dec.alu; reg_load[LD_Z] = 1'b1;
                    end
                    CL_ALU_I: begin
                        bus_src[BUS_C] = 1'b1; ALU_select = dec.alu; reg_load[LD_Z] = 1'b1;
                    end
                    CL_LD, CL_LDI, CL_ST: begin
                        bus_src[BUS_C] = 1'b1; ALU_select = ALU_ADD; reg_load[LD_Z] = 1'b1;
                    end
                    CL_MULDIV: begin
                        sel_ctl[SEL_GRB] = 1'b1; sel_ctl[SEL_ROUT] = 1'b1;
                        ALU_select = dec.alu; reg_load[LD_Z] = 1'b1;
                    end
                    CL_UNARY: begin
                        bus_src[BUS_ZLO] = 1'b1; sel_ctl[SEL_GRA] = 1'b1; sel_ctl[SEL_RIN] = 1'b1;
                    end
                    CL_BR: begin
                        bus_src[BUS_PC] = 1'b1; reg_load[LD_Y] = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (dec.cls)
                    CL_ALU_R, CL_ALU_I, CL_LDI: begin
                        bus_src[BUS_ZLO] = 1'b1; sel_ctl[SEL_GRA] = 1'b1; sel_ctl[SEL_RIN] = 1'b1;
                    end
                    CL_LD, CL_ST: begin
                        bus_src[BUS_ZLO] = 1'b1; reg_load[LD_MAR] = 1'b1;
                    end
                    CL_MULDIV: begin
                        bus_src[BUS_ZLO] = 1'b1; reg_load[LD_LO] = 1'b1;
                    end
                    CL_BR: begin
                        bus_src[BUS_C] = 1'b1; ALU_select = ALU_ADD; reg_load[LD_Z] = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (dec.cls)
                    CL_LD: begin
                        read = 1'b1; reg_load[LD_MDR] = 1'b1;
                    end
                    CL_ST: begin
                        sel_ctl[SEL_GRA] = 1'b1; sel_ctl[SEL_ROUT] = 1'b1; reg_load[LD_MDR] = 1'b1;
                    end
                    CL_MULDIV: begin
                        bus_src[BUS_ZHI] = 1'b1; reg_load[LD_HI] = 1'b1;
                    end
                    CL_BR: begin
                        bus_src[BUS_ZLO] = 1'b1; reg_load[LD_PC] = CON_out;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (dec.cls)
                    CL_LD: begin
                        bus_src[BUS_MDR] = 1'b1; sel_ctl[SEL_GRA] = 1'b1; sel_ctl[SEL_RIN] = 1'b1;
                    end
                    CL_ST: write = 1'b1;
                    default: ;
                endcase
            end
            S_HALT: Run = 1'b0;
`ifdef CU_SINGLE_STEP_EN
            S_STEP_WAIT: Run = 1'b0;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
module tb_control_sequencer;

    localparam logic [4:0] ST_RST  = 5'd0;
    localparam logic [4:0] ST_F0   = 5'd1;
    localparam logic [4:0] ST_F1   = 5'd2;
    localparam logic [4:0] ST_T3   = 5'd4;
    localparam logic [4:0] ST_T4   = 5'd5;
    localparam logic [4:0] ST_T6   = 5'd7;
    localparam logic [4:0] ST_T7   = 5'd8;
    localparam logic [4:0] ST_HALT = 5'd9;
    localparam logic [4:0] M_RUN   = 5'b00010;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] IR_data;
    logic        CON_out;
    logic        mem_ready;
    logic [4:0]  sel_ctl;
    logic [8:0]  bus_src;
    logic [9:0]  reg_load;
    logic        Inc_PC;
    logic        read;
    logic        write;
    logic [3:0]  ALU_select;
    logic        Run;
    logic        mem_err;
    logic [4:0]  state_dbg;

    int total = 0;
    int bad   = 0;
    int n;
    int w;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk        (clk),
        .clr        (clr),
        .IR_data    (IR_data),
        .CON_out    (CON_out),
        .mem_ready  (mem_ready),
        .sel_ctl    (sel_ctl),
        .bus_src    (bus_src),
        .reg_load   (reg_load),
        .Inc_PC     (Inc_PC),
        .read       (read),
        .write      (write),
        .ALU_select (ALU_select),
        .Run        (Run),
        .mem_err    (mem_err),
        .state_dbg  (state_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("onehot_bus", 32'($countones(bus_src) <= 1), 32'd1);
    endtask

    // misc = {Inc_PC, read, write, Run, mem_err}
    task automatic exp_cyc(input string tag, input logic [4:0] st, input logic [4:0] sel,
                           input logic [8:0] bus, input logic [9:0] rl, input logic [3:0] alu,
                           input logic [4:0] misc);
        chk({tag, ".state"}, 32'(state_dbg), 32'(st));
        chk({tag, ".sel"},   32'(sel_ctl), 32'(sel));
        chk({tag, ".bus"},   32'(bus_src), 32'(bus));
        chk({tag, ".load"},  32'(reg_load), 32'(rl));
        chk({tag, ".alu"},   32'(ALU_select), 32'(alu));
        chk({tag, ".misc"},  32'({Inc_PC, read, write, Run, mem_err}), 32'(misc));
    endtask

    task automatic measure(input string tag, input logic [4:0] opc, input int exp_n);
        int k;
        k = 0;
        IR_data = {opc, 27'd0};
        do begin
            tick();
            k++;
        end while (state_dbg != ST_F0 && k < 300);
        chk(tag, 32'(k), 32'(exp_n));
    endtask

    initial begin
        clr = 1'b1; IR_data = 32'd0; CON_out = 1'b0; mem_ready = 1'b1;
        tick(); tick();
        exp_cyc("rst", ST_RST, 5'h00, 9'h000, 10'h000, 4'd0, M_RUN);
        clr = 1'b0;
        tick();
        exp_cyc("f0", ST_F0, 5'h00, 9'h020, 10'h008, 4'd0, 5'b10010);

        IR_data = {5'd3, 4'd5, 4'd2, 4'd4, 15'd0};
        tick(); exp_cyc("add_f1", ST_F1, 5'h00, 9'h000, 10'h004, 4'd0, 5'b01010);
        tick(); exp_cyc("add_f2", 5'd3, 5'h00, 9'h010, 10'h100, 4'd0, M_RUN);
        tick(); exp_cyc("add_t3", ST_T3, 5'h09, 9'h000, 10'h080, 4'd0, M_RUN);
        tick(); exp_cyc("add_t4", ST_T4, 5'h05, 9'h000, 10'h040, 4'd1, M_RUN);
        tick(); exp_cyc("add_t5", 5'd6, 5'h12, 9'h004, 10'h000, 4'd0, M_RUN);
        tick(); chk("add_done", 32'(state_dbg), 32'(ST_F0));

        repeat (4) tick();
        chk("add2_in_t4", 32'(state_dbg), 32'(ST_T4));
        clr = 1'b1;
        tick(); exp_cyc("clr_abort", ST_RST, 5'h00, 9'h000, 10'h000, 4'd0, M_RUN);
        tick(); chk("clr_hold", 32'(state_dbg), 32'(ST_RST));
        clr = 1'b0;
        tick(); exp_cyc("clr_f0", ST_F0, 5'h00, 9'h020, 10'h008, 4'd0, 5'b10010);

        IR_data = {5'd0, 4'd1, 4'd2, 19'h54};
        n = 0;
        tick(); tick(); tick(); n = n + 3;
        exp_cyc("ld_t3", ST_T3, 5'h08, 9'h080, 10'h080, 4'd0, M_RUN);
        tick(); n++;
        exp_cyc("ld_t4", ST_T4, 5'h00, 9'h040, 10'h040, 4'd1, M_RUN);
        tick(); n++;
        exp_cyc("ld_t5", 5'd6, 5'h00, 9'h004, 10'h008, 4'd0, M_RUN);
        mem_ready = 1'b0;
        w = 0;
        do begin
            tick(); n++;
            if (state_dbg == ST_T6) begin
                w++;
                chk("ld_t6_rd", 32'({read, reg_load}), 32'({1'b1, 10'h004}));
            end
            if (w == 4) mem_ready = 1'b1;
        end while (state_dbg == ST_T6 && w < 50);
        chk("ld_t6_cycles", 32'(w), 32'd4);
        exp_cyc("ld_t7", ST_T7, 5'h12, 9'h010, 10'h000, 4'd0, M_RUN);
        tick(); n++;
        chk("ld_total", 32'(n), 32'd11);
        chk("ld_done", 32'(state_dbg), 32'(ST_F0));

        for (int c = 0; c < 2; c++) begin
            CON_out = (c == 1);
            IR_data = {5'd18, 27'd0};
            tick(); tick(); tick();
            exp_cyc("br_t3", ST_T3, 5'h11, 9'h000, 10'h001, 4'd0, M_RUN);
            tick(); tick(); tick();
            chk("br_t6", 32'(state_dbg), 32'(ST_T6));
            chk("br_pcin", 32'(reg_load[9]), 32'(c));
            if (c == 1) chk("br_zlo", 32'(bus_src), 32'h004);
            tick();
            chk("br_done", 32'(state_dbg), 32'(ST_F0));
        end
        CON_out = 1'b0;

        IR_data = {5'd2, 27'd0};
        repeat (6) tick();
        exp_cyc("st_t6", ST_T6, 5'h11, 9'h000, 10'h004, 4'd0, M_RUN);
        tick(); exp_cyc("st_t7", ST_T7, 5'h00, 9'h000, 10'h000, 4'd0, 5'b00110);
        tick(); chk("st_done", 32'(state_dbg), 32'(ST_F0));

        IR_data = {5'd20, 27'd0};
        tick(); tick(); tick();
        exp_cyc("in_t3", ST_T3, 5'h12, 9'h100, 10'h000, 4'd0, M_RUN);
        tick(); chk("in_done", 32'(state_dbg), 32'(ST_F0));

        measure("lat_mul", 5'd14, 7);
        measure("lat_neg", 5'd16, 5);
        measure("lat_nop", 5'd24, 3);
        measure("lat_undef", 5'h1F, 3);
        measure("lat_sub", 5'd4, 6);

        IR_data = {5'd25, 27'd0};
        tick(); tick(); tick();
        exp_cyc("halt", ST_HALT, 5'h00, 9'h000, 10'h000, 4'd0, 5'b00000);
        tick(); tick();
        chk("halt_stays", 32'(state_dbg), 32'(ST_HALT));
        clr = 1'b1; tick();
        clr = 1'b0; tick();
        chk("halt_recover", 32'(state_dbg), 32'(ST_F0));

        mem_ready = 1'b0;
        w = 0;
        do begin
            tick();
            if (state_dbg == ST_F1) w++;
        end while (state_dbg == ST_F1 && w < 400);
        chk("tmo_wait_cycles", 32'(w), 32'd255);
        exp_cyc("tmo_halt", ST_HALT, 5'h00, 9'h000, 10'h000, 4'd0, 5'b00001);
        tick();
        chk("tmo_sticky", 32'(mem_err), 32'd1);
        mem_ready = 1'b1;
        clr = 1'b1;
        tick();
        exp_cyc("tmo_clr", ST_RST, 5'h00, 9'h000, 10'h000, 4'd0, M_RUN);
        clr = 1'b0;
        tick();
        chk("tmo_clr_f0", 32'(state_dbg), 32'(ST_F0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Hardwired control unit for the 32-bit bus datapath. It steps a Moore FSM through fetch and per-instruction-class execute steps and drives every bus-source select, register load strobe, ALU_select and memory strobe. Register selection is done through Gra/Grb/Grc/Rin/Rout into the existing select/encode logic. It waits on a memory-ready handshake and halts on a memory timeout.

Parameters:
OPC_W, 5, opcode width; opcode = IR_data[31:27]
MEM_TIMEOUT, 255, max wait cycles for mem_ready before error halt (8-bit counter)

Ports:
clk  in  1  system clock
clr  in  1  synchronous active-high reset
IR_data  in  32  current instruction register contents
CON_out  in  1  branch condition flag from CON FF
mem_ready  in  1  memory read data valid / write accepted
sel_ctl  out  5  {Gra,Grb,Grc,Rin,Rout}, bit4..bit0
bus_src  out  9  one-hot {inPortout,BAout,Cout,PCout,MDRout,ZHIout,ZLOWout,HIout,LOout}
reg_load  out  10  {PC_in,IR_in,Y_in,Z_in,HI_in,LO_in,MAR_in,MDR_in,outPort_in,CON_in}
Inc_PC  out  1  PC increment
read  out  1  memory read / MDR source = MdataIn
write  out  1  memory write strobe
ALU_select  out  4  ALU op code
Run  out  1  1 while executing; 0 in HALT
mem_err  out  1  sticky; set on memory timeout
state_dbg  out  5  current state encoding

Behaviour:
- All outputs are decoded from the state register and IR_data. No output depends on clr directly.
- On a clr edge the state becomes RST and the timeout counter clears. In RST every output is 0 except Run=1; mem_err=0.
- A clr asserted mid-instruction aborts the instruction at the next edge.
- RST -> F0 after 1 cycle.
- F0: PCout, MAR_in, Inc_PC.
- F1: read, MDR_in. Hold in F1 while mem_ready=0.
- F2: MDRout, IR_in.
- After F2, IR_data is already the new instruction and the class decode selects T3.
- Bus rule: at most one bus_src bit is high in any state.
- ALU R-type (add, sub, and, or, shl, shr, rol, ror):
  - T3: Grb, Rout, Y_in
  - T4: Grc, Rout, ALU_select=op, Z_in
  - T5: ZLOWout, Gra, Rin
  - then F0
- ALU I-type (addi, andi, ori): as R-type, except T4 uses Cout in place of Grc/Rout.
- ld:
  - T3: Grb, BAout, Y_in
  - T4: Cout, ADD, Z_in
  - T5: ZLOWout, MAR_in
  - T6: read, MDR_in (wait on mem_ready)
  - T7: MDRout, Gra, Rin
- ldi: T3–T4 as ld; T5: ZLOWout, Gra, Rin.
- st:
  - T3–T5 as ld
  - T6: Gra, Rout, MDR_in, read=0
  - T7: write, held until mem_ready
- mul/div:
  - T3: Gra, Rout, Y_in
  - T4: Grb, Rout, op, Z_in
  - T5: ZLOWout, LO_in
  - T6: ZHIout, HI_in
- neg/not: T3: Grb, Rout, op, Z_in; T4: ZLOWout, Gra, Rin.
- brcond:
  - T3: Gra, Rout, CON_in
  - T4: PCout, Y_in
  - T5: Cout, ADD, Z_in
  - T6: ZLOWout, PC_in only if CON_out=1
- jr: T3: Gra, Rout, PC_in.
- in: T3: inPortout, Gra, Rin.
- out: T3: Gra, Rout, outPort_in.
- mfhi/mflo: T3: HIout or LOout, with Gra, Rin.
- nop and undefined opcodes: F2 -> F0.
- halt: -> HALT. HALT is absorbing until clr; Run=0, all strobes 0.
- Memory wait (F1, ld T6, st T7): the counter increments each wait cycle.
  - If the counter reaches MEM_TIMEOUT with mem_ready=0: go to HALT and set mem_err.
  - The counter clears on state exit.
  - mem_ready high in the first wait cycle means zero added latency.
- Latencies: fetch 3 cycles; R-type 6; ld/st 8; mul/div 7; in/out/jr/mf 4.

Optional Feature:
- CU_SINGLE_STEP_EN adds input step (1 bit).
- With the macro: the FSM enters STEP_WAIT before every F0 (including after RST) with Run=0. It advances to F0 on the first clk with step=1; one step pulse runs exactly one instruction.
- Without the macro: no step port, no STEP_WAIT state, and the encoding is unchanged otherwise.

Decomposition:
- Package cu_pkg holds:
  - the opcode enum (5-bit)
  - the state enum
  - ALU_select constants (ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, MUL, DIV, NEG, NOT)
  - bit-index constants for sel_ctl, bus_src and reg_load
  - the opcode-to-class/ALU-op function
- Sub-module mem_wait_timer: counter, clear, timeout flag.

Test Plan:
- clr held 2 cycles mid-T4 of add -> next cycle state RST, all strobes 0; then F0 with PCout=MAR_in=Inc_PC=1.
- add R5,R2,R4 with mem_ready tied 1 -> 6 cycles. T4 shows Grc, Rout, ALU_select=ADD, Z_in; T5 shows ZLOWout, Gra, Rin.
- ld R1,0x54(R2) with mem_ready delayed 3 cycles in T6 -> read/MDR_in held 4 cycles; total 11 cycles; T7 MDRout, Rin.
- brzr with CON_out=0, then 1 -> PC_in absent, then asserted in T6 with ZLOWout.
- mem_ready stuck 0 in F1 -> after 255 wait cycles state HALT, mem_err=1, Run=0; clr restores mem_err=0.
- Check every state for one-hot bus_src. Opcode 0x1F undefined -> F2 to F0 with no strobes beyond fetch.
